// File: rtl/wb_bridge_pkg.sv
// Shared types and Wishbone tag constants for the multi-master bridge and its arbiter.
package wb_bridge_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int PTR_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      automatic int idx = (int'(ptr) + i) % NUM_MASTERS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_multi_master_bridge.sv
// N-master to single-slave Wishbone bridge: round-robin grant with burst/atomic locking,
// registered one-cycle ack/err responses and a slave-ack timeout.
module wb_multi_master_bridge
  import wb_bridge_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]        m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]        m_bte_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_WIDTH-1:0]           s_adr_o,
  output logic [DATA_WIDTH-1:0]           s_dat_o,
  output logic [SEL_WIDTH-1:0]            s_sel_o,
  input  logic [DATA_WIDTH-1:0]           s_dat_i,
  input  logic                            s_ack_i
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MASTERS - 1);

  state_t                 state, state_next;
  logic [PTR_W-1:0]       ptr, gidx, arb_idx;
  logic [NUM_MASTERS-1:0] req, arb_gnt;
  logic [CNT_W-1:0]       cnt;
  logic                   g_cyc, g_stb;
  logic                   latch, take_ack, take_err, release_g;
  logic                   eob, unused_tags;

  assign req   = m_cyc_i & m_stb_i;
  assign g_cyc = m_cyc_i[gidx];
  assign g_stb = m_stb_i[gidx];

  // Burst tags carry no behaviour here: the grant follows m_cyc_i alone.
  assign eob         = (m_cti_i[gidx*3 +: 3] == CTI_END);
  assign unused_tags = ^{eob, m_bte_i};

  rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .PTR_W(PTR_W)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    take_ack   = 1'b0;
    take_err   = 1'b0;
    release_g  = 1'b0;
    unique case (state)
      IDLE:  if (|req) state_next = ISSUE;
      ISSUE: begin
        if (!g_cyc) begin
          release_g  = 1'b1;
          state_next = IDLE;
        end else if (g_stb) begin
          latch      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A master abort wins over a same-cycle slave ack, which is then dropped.
        if (!g_cyc) begin
          release_g  = 1'b1;
          state_next = IDLE;
        end else if (s_ack_i) begin
          take_ack   = 1'b1;
          state_next = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_MAX) begin
          take_err   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (g_cyc) begin
          state_next = ISSUE;
        end else begin
          release_g  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      gidx    <= '0;
      cnt     <= '0;
      s_cyc_o <= 1'b0;
      s_stb_o <= 1'b0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      s_sel_o <= '0;
      m_ack_o <= '0;
      m_err_o <= '0;
      m_dat_o <= '0;
    end else begin
      m_ack_o <= '0;
      m_err_o <= '0;
      if (state == IDLE && |req) begin
        gidx    <= arb_idx;
        s_cyc_o <= 1'b1;
      end
      if (latch) begin
        s_stb_o <= 1'b1;
        s_we_o  <= m_we_i[gidx];
        s_adr_o <= m_adr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o <= m_dat_i[gidx*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o <= m_sel_i[gidx*SEL_WIDTH +: SEL_WIDTH];
        cnt     <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (take_ack || take_err) begin
        s_stb_o       <= 1'b0;
        m_ack_o[gidx] <= take_ack;
        m_err_o[gidx] <= take_err;
        m_dat_o[gidx*DATA_WIDTH +: DATA_WIDTH] <= take_ack ? s_dat_i : '0;
      end
      if (release_g) begin
        s_cyc_o <= 1'b0;
        s_stb_o <= 1'b0;
        ptr     <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_multi_master_bridge.sv
// Scoreboard bench for wb_multi_master_bridge: two masters, latency-programmable slave.
module tb_wb_multi_master_bridge;
  import wb_bridge_pkg::*;

  localparam int NM = 2, AW = 32, DW = 32, SW = 4, TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i, m_dat_o;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*2-1:0]  m_bte_i;
  logic             s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o, s_dat_i;
  logic [SW-1:0]    s_sel_o;

  typedef struct {
    bit          err;
    bit          chk_dat;
    logic [31:0] dat;
    int          lat;
  } rsp_t;

  rsp_t exp_q[NM][$];
  int   order_q[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc_n = 0, stb_rise = 0, cyc_gaps = 0, slave_acks = 0;
  int   slave_lat = 0, wcnt = 0;
  bit   slave_mute = 0, ack_given = 0, watch = 0, stb_prev = 0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  wb_multi_master_bridge #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
  endfunction

  // Slave: acks slave_lat cycles after s_stb_o rises, one-cycle pulse, unless muted.
  initial begin
    s_ack_i = 1'b0;
    s_dat_i = '0;
    forever begin
      @(negedge clk);
      s_ack_i = 1'b0;
      if (!s_stb_o) begin
        wcnt      = 0;
        ack_given = 0;
      end else if (!slave_mute && !ack_given) begin
        if (wcnt == slave_lat) begin
          s_ack_i   = 1'b1;
          s_dat_i   = slv_data(s_adr_o);
          cap_adr   = s_adr_o;
          cap_dat   = s_dat_o;
          cap_sel   = s_sel_o;
          cap_we    = s_we_o;
          ack_given = 1;
          slave_acks++;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Response monitor: pops the per-master scoreboard on every ack/err pulse.
  initial forever begin
    @(negedge clk);
    if (s_stb_o === 1'b1 && !stb_prev) stb_rise = cyc_n;
    stb_prev = (s_stb_o === 1'b1);
    if (watch && s_cyc_o !== 1'b1) cyc_gaps++;
    for (int i = 0; i < NM; i++) begin
      if (m_ack_o[i] === 1'b1 || m_err_o[i] === 1'b1) begin
        order_q.push_back(i);
        check_val($sformatf("rsp_expected_m%0d", i), 64'(exp_q[i].size() > 0), 64'd1);
        if (exp_q[i].size() > 0) begin
          automatic rsp_t e = exp_q[i].pop_front();
          check_val($sformatf("ack_err_m%0d", i), 64'({m_ack_o[i], m_err_o[i]}),
                    e.err ? 64'd1 : 64'd2);
          if (e.chk_dat)
            check_val($sformatf("rdata_m%0d", i), 64'(m_dat_o[i*DW +: DW]), 64'(e.dat));
          check_val($sformatf("latency_m%0d", i), 64'(cyc_n - stb_rise), 64'(e.lat));
        end
      end
    end
  end

  task automatic drive_req(input int m, input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat, input logic [2:0] cti);
    m_cyc_i[m]          = 1'b1;
    m_stb_i[m]          = 1'b1;
    m_we_i[m]           = we;
    m_adr_i[m*AW +: AW] = adr;
    m_dat_i[m*DW +: DW] = dat;
    m_sel_i[m*SW +: SW] = sel;
    m_cti_i[m*3 +: 3]   = cti;
    m_bte_i[m*2 +: 2]   = BTE_LINEAR;
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic master_beat(input int m, input logic we, input logic [31:0] adr,
                             input logic [3:0] sel, input logic [31:0] dat, input logic [2:0] cti,
                             input bit keep, input bit exp_err, input logic [31:0] exp_dat,
                             input bit chk_dat, input int lat);
    int n = 0;
    rsp_t e;
    e.err = exp_err; e.chk_dat = chk_dat; e.dat = exp_dat; e.lat = lat;
    exp_q[m].push_back(e);
    drive_req(m, we, adr, sel, dat, cti);
    do begin
      @(negedge clk);
      n++;
    end while (!(m_ack_o[m] === 1'b1 || m_err_o[m] === 1'b1) && n < 200);
    check_val($sformatf("beat_done_m%0d", m), 64'(n < 200), 64'd1);
    if (!keep) begin
      m_cyc_i[m] = 1'b0;
      m_stb_i[m] = 1'b0;
    end
  endtask

  task automatic check_order(input string tag, input int exp_ord[$]);
    check_val({tag, "_count"}, 64'(order_q.size()), 64'(exp_ord.size()));
    for (int k = 0; k < exp_ord.size() && k < order_q.size(); k++)
      check_val($sformatf("%s_%0d", tag, k), 64'(order_q[k]), 64'(exp_ord[k]));
  endtask

  initial begin
    int acks0, rsp0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_outputs_zero", 64'(|{m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o,
                                           s_we_o, s_adr_o, s_dat_o, s_sel_o}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    slave_lat = 2;
    master_beat(0, 1'b0, 32'h100, 4'hF, 32'h0, CTI_CLASSIC, 0, 0, 32'hDEADBEEF, 1, 3);
    check_val("read_dat_held", 64'(m_dat_o[31:0]), 64'hDEADBEEF);
    repeat (2) @(negedge clk);

    slave_lat = 0;
    master_beat(1, 1'b1, 32'h200, 4'h3, 32'h1234, CTI_CLASSIC, 0, 0, 32'h0, 0, 1);
    check_val("wr_adr", 64'(cap_adr), 64'h200);
    check_val("wr_sel", 64'(cap_sel), 64'h3);
    check_val("wr_dat", 64'(cap_dat), 64'h1234);
    check_val("wr_we", 64'(cap_we), 64'd1);
    check_val("m0_dat_unchanged", 64'(m_dat_o[31:0]), 64'hDEADBEEF);
    repeat (2) @(negedge clk);

    slave_lat = 1;
    order_q.delete();
    cyc_gaps = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          master_beat(0, 1'b0, 32'(32'h300 + 4*k), 4'hF, 32'h0, (k == 3) ? CTI_END : CTI_INCR,
                      (k < 3), 0, slv_data(32'(32'h300 + 4*k)), 1, 2);
          if (k == 0) watch = 1;
        end
        watch = 0;
      end
      begin
        @(negedge clk);
        master_beat(1, 1'b0, 32'h400, 4'hF, 32'h0, CTI_CLASSIC, 0, 0, slv_data(32'h400), 1, 2);
      end
    join
    check_val("burst_cyc_gaps", 64'(cyc_gaps), 64'd0);
    check_order("burst_order", '{0, 0, 0, 0, 1});
    repeat (2) @(negedge clk);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    slave_lat = 3;
    order_q.delete();
    for (int r = 0; r < 2; r++) begin
      fork
        master_beat(0, 1'b0, 32'(32'h600 + 16*r), 4'hF, 32'h0, CTI_CLASSIC, 0, 0,
                    slv_data(32'(32'h600 + 16*r)), 1, 4);
        master_beat(1, 1'b0, 32'(32'h680 + 16*r), 4'hF, 32'h0, CTI_CLASSIC, 0, 0,
                    slv_data(32'(32'h680 + 16*r)), 1, 4);
      join
      @(negedge clk);
    end
    check_order("rr_order", '{0, 1, 0, 1});

    slave_mute = 1;
    master_beat(0, 1'b0, 32'h700, 4'hF, 32'h0, CTI_CLASSIC, 0, 1, 32'h0, 1, TO + 1);
    @(negedge clk);
    check_val("timeout_cyc_drop", 64'(s_cyc_o), 64'd0);
    slave_mute = 0;
    repeat (2) @(negedge clk);

    slave_lat = 2;
    acks0 = slave_acks;
    rsp0  = order_q.size();
    drive_req(0, 1'b0, 32'h500, 4'hF, 32'h0, CTI_CLASSIC);
    repeat (4) @(negedge clk);
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    @(negedge clk);
    check_val("abort_bus_idle", 64'({s_cyc_o, s_stb_o}), 64'd0);
    check_val("abort_slave_acked", 64'(slave_acks - acks0), 64'd1);
    repeat (5) @(negedge clk);
    check_val("abort_no_response", 64'(order_q.size()), 64'(rsp0));
    check_val("abort_m0_dat", 64'(m_dat_o[31:0]), 64'd0);
    master_beat(1, 1'b0, 32'h800, 4'hF, 32'h0, CTI_CLASSIC, 0, 0, slv_data(32'h800), 1, 3);
    repeat (2) @(negedge clk);

    slave_mute = 1;
    drive_req(0, 1'b1, 32'h900, 4'hF, 32'hCAFE, CTI_CLASSIC);
    repeat (4) @(negedge clk);
    check_val("rstw_in_wait", 64'(s_stb_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_outputs_zero", 64'(|{m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o,
                                             s_we_o, s_adr_o, s_dat_o, s_sel_o}), 64'd0);
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    rst = 1'b0;
    slave_mute = 0;
    repeat (3) @(negedge clk);

    check_val("scoreboard_empty", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_multi_master_bridge.md
# wb_multi_master_bridge

Parametrised Wishbone bridge between a processor's N Wishbone B3 master ports (instruction, data, extra cores) and one classic single-beat memory/controller port. It adds round-robin arbitration with bus locking, a registered response stage that gives every master a clean one-cycle ack/data pair, and a slave-ack timeout that reports errors instead of hanging the core. It sits between the core instance and the Controller bus in each `processorci_top`.

## Interface
Parameters:
- NUM_MASTERS, 2, number of master ports (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width, multiple of 8; SEL_WIDTH = DATA_WIDTH/8 derived
- TIMEOUT_CYCLES, 255, slave-ack wait limit; 0 disables timeout

Ports (master buses packed, master i at slice i):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS each  master cycle/strobe/write
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master address
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data
- m_sel_i  in  NUM_MASTERS*SEL_WIDTH  byte selects
- m_cti_i  in  NUM_MASTERS*3, m_bte_i in NUM_MASTERS*2  burst tags; used only for the end-of-burst flag
- m_dat_o  out  NUM_MASTERS*DATA_WIDTH  read data, registered
- m_ack_o, m_err_o  out  NUM_MASTERS  one-cycle response pulses
- s_cyc_o, s_stb_o, s_we_o  out  1  slave cycle/strobe/write
- s_adr_o  out  ADDR_WIDTH, s_dat_o  out  DATA_WIDTH, s_sel_o  out  SEL_WIDTH
- s_dat_i  in  DATA_WIDTH, s_ack_i  in  1  slave read data / acknowledge

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: no grant. If any m_cyc_i&m_stb_i is set, the rr_arbiter picks the first requester at or after the priority pointer. Go to ISSUE.
- ISSUE (granted): when the granted master's cyc&stb is sampled high, latch adr/dat/sel/we into the slave output registers and go to WAIT.
- WAIT: s_cyc_o=s_stb_o=1. On s_ack_i, capture s_dat_i and go to RESP. If the wait counter reaches TIMEOUT_CYCLES, go to RESP with the error flag set.
- RESP: s_stb_o=0. Pulse m_ack_o[g] with the captured data, or pulse m_err_o[g] with data 0.
  - Granted master still holds m_cyc_i: go to ISSUE; the grant is kept for bursts and atomics.
  - Otherwise: release the grant, set pointer = g+1 mod NUM_MASTERS, go to IDLE.
- Grant release in ISSUE: if the granted master drops m_cyc_i, release the grant and advance the pointer.
- Abort: if the granted master drops m_cyc_i during WAIT, deassert s_cyc_o/s_stb_o next cycle and return to IDLE without any master response. A slave ack arriving in that same cycle is discarded.
- s_cyc_o stays high from ISSUE entry while the grant is held. It also stays high across RESP→ISSUE inside a burst.
- A cti=111 beat is treated like any other beat. The grant follows m_cyc_i only.
- m_dat_o[g] holds the last read value until the next response to master g.

## Timing
- Reset: all outputs 0, FSM IDLE, pointer 0, counters 0. Reset mid-transfer drops s_cyc_o/s_stb_o on the next edge with no response.
- Single beat, slave ack latency L≥0 cycles after s_stb_o rises:
  - edge 0: request sampled in IDLE
  - edge 1: latched in ISSUE
  - s_stb_o visible from cycle 2
  - ack seen at cycle 2+L
  - m_ack_o high in cycle 3+L for exactly one cycle
- Burst beats: 3+L cycles per beat. The master's next beat is sampled in ISSUE, the cycle after RESP.
- Timeout: m_err_o asserts TIMEOUT_CYCLES+1 cycles after s_stb_o rises.
- Simultaneous requests: lowest index at or after the pointer wins. Others wait with no response.
- NUM_MASTERS=1: the pointer is constant 0.

## Structure
- Package wb_bridge_pkg holds:
  - the state enum
  - CTI constants: CLASSIC=000, CONST=001, INCR=010, END=111
  - BTE constants
- Sub-module rr_arbiter (NUM_MASTERS): combinational one-hot grant from the request vector and the pointer. It is reused by later multi-core tops.

## Test plan
- Single read, master 0, adr 0x100, slave returns 0xDEADBEEF with L=2 → m_ack_o[0] pulses at cycle 5 only, m_dat_o slice 0 = 0xDEADBEEF.
- Write, master 1, adr 0x200, sel 0x3, dat 0x1234 → s_adr_o=0x200, s_sel_o=0x3, s_dat_o=0x1234, s_we_o=1; one m_ack_o[1] pulse.
- 4-beat INCR read burst from master 0 (cti 010,010,010,111) with master 1 requesting throughout → four acks to master 0, s_cyc_o continuously high, then master 1 is granted.
- Both masters request in the same cycle after reset → master 0 first. Repeating → master 1 next (alternation).
- Slave never acks, TIMEOUT_CYCLES=8 → m_err_o pulses once, 9 cycles after s_stb_o rises; s_cyc_o drops if the master releases m_cyc_i.
- Master drops m_cyc_i during WAIT, then the slave acks → no m_ack_o, FSM returns to IDLE. Reset asserted mid-WAIT → all outputs 0 on the next edge.
